// File: rtl/jk_flipflop.sv
// Bank of WIDTH independent positive-edge JK flip-flops with asynchronous
// active-low reset and a complementary output taken from the same register.
module jk_flipflop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB
);

  logic [WIDTH-1:0] q_next;

  // Characteristic equation Q+ = J&~Q | ~K&Q, bitwise so each bit (and any X)
  // stays confined to its own lane.
  always_comb begin
    q_next = (J & ~Q) | (~K & Q);
  end

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q <= RESET_VALUE;
    end else begin
      Q <= q_next;
    end
  end

  assign QB = ~Q;

endmodule

// File: tb/tb_jk_flipflop.sv
// Scoreboard bench for jk_flipflop: a 1-bit default instance and a 4-bit
// instance with a non-zero reset value, driven by directed vectors.
module tb_jk_flipflop;

  typedef struct {
    string      name;
    int         inst;
    logic [3:0] q;
    logic [3:0] qb;
  } exp_t;

  logic       clk;
  logic       rst_n0, rst_n1;
  logic [0:0] j0, k0, q0, qb0;
  logic [3:0] j1, k1, q1, qb1;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jk_flipflop u_dut0 (
    .clk   (clk),
    .rst_n (rst_n0),
    .J     (j0),
    .K     (k0),
    .Q     (q0),
    .QB    (qb0)
  );

  jk_flipflop #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .J     (j1),
    .K     (k1),
    .Q     (q1),
    .QB    (qb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops each expectation as soon as it is posted and compares
  // against the instance it names.
  initial begin
    exp_t       e;
    logic [3:0] aq, aqb;
    forever begin
      wait (sb.size() > 0);
      e = sb.pop_front();
      if (e.inst == 0) begin
        aq  = {3'b000, q0};
        aqb = {3'b000, qb0};
      end else begin
        aq  = q1;
        aqb = qb1;
      end
      checks++;
      if (aq !== e.q || aqb !== e.qb) begin
        errors++;
        $display("FAIL %s: got Q=%b QB=%b, expected Q=%b QB=%b",
                 e.name, aq, aqb, e.q, e.qb);
      end
    end
  end

  task automatic expect1(input string name, input logic q);
    exp_t e;
    e.name = name; e.inst = 0;
    e.q = {3'b000, q}; e.qb = {3'b000, ~q};
    sb.push_back(e);
  endtask

  task automatic expect4(input string name, input logic [3:0] q, input logic [3:0] qb);
    exp_t e;
    e.name = name; e.inst = 1; e.q = q; e.qb = qb;
    sb.push_back(e);
  endtask

  // Drive J/K at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step1(input logic j, input logic k, input string name, input logic q);
    @(negedge clk);
    j0 = j; k0 = k;
    @(posedge clk);
    #1;
    expect1(name, q);
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    j0 = 1'b1; k0 = 1'b0;
    j1 = 4'b0000; k1 = 4'b0000;

    // Reset held with a set command and the clock running.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expect1("reset_hold", 1'b0);
    end
    @(negedge clk);
    rst_n0 = 1'b1;
    @(posedge clk);
    #1;
    expect1("reset_release_set", 1'b1);

    // Async reset between edges, then command sequence 00,01,10,11,00.
    @(negedge clk);
    rst_n0 = 1'b0;
    #1;
    expect1("async_reset_from_1", 1'b0);
    j0 = 1'b0; k0 = 1'b0;
    @(negedge clk);
    rst_n0 = 1'b1;
    step1(1'b0, 1'b0, "cmd_hold", 1'b0);
    step1(1'b0, 1'b1, "cmd_reset", 1'b0);
    step1(1'b1, 1'b0, "cmd_set", 1'b1);
    step1(1'b1, 1'b1, "cmd_toggle", 1'b0);
    step1(1'b0, 1'b0, "cmd_hold2", 1'b0);

    // Repeated toggle from 0, with J/K wiggled between edges.
    for (int i = 0; i < 4; i++) begin
      step1(1'b1, 1'b1, "toggle_seq", (i % 2 == 0) ? 1'b1 : 1'b0);
      j0 = 1'b0; k0 = 1'b1;
      #2;
      expect1("toggle_midcycle_stable", (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Set to 1, then pull reset low halfway between edges.
    step1(1'b1, 1'b0, "set_before_async", 1'b1);
    #4;
    rst_n0 = 1'b0;
    #1;
    expect1("async_reset_midcycle", 1'b0);

    // Reset falling at the same time step as a rising edge with J=1,K=0.
    @(negedge clk);
    j0 = 1'b0; k0 = 1'b0;
    rst_n0 = 1'b1;
    @(posedge clk);
    #1;
    expect1("hold_after_release", 1'b0);
    @(negedge clk);
    j0 = 1'b1; k0 = 1'b0;
    @(posedge clk);
    rst_n0 = 1'b0;
    #1;
    expect1("reset_edge_coincide", 1'b0);

    // Multi-bit instance with RESET_VALUE=1010.
    expect4("mb_reset", 4'b1010, 4'b0101);
    @(negedge clk);
    rst_n1 = 1'b1;
    @(posedge clk);
    #1;
    expect4("mb_hold", 4'b1010, 4'b0101);
    @(negedge clk);
    j1 = 4'b0011; k1 = 4'b0101;
    @(posedge clk);
    #1;
    expect4("mb_mixed_cmds", 4'b1011, 4'b0100);
    @(negedge clk);
    j1 = 4'b1111; k1 = 4'b1111;
    @(posedge clk);
    #1;
    expect4("mb_toggle_all", 4'b0100, 4'b1011);
    @(negedge clk);
    j1 = 4'b0000; k1 = 4'b0000;
    rst_n1 = 1'b0;
    #1;
    expect4("mb_async_reset", 4'b1010, 4'b0101);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 100 && sb.size() > 0; i++) #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
